// File: rtl/laa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laa_pkg
// Description : Shared types and constants for the LAA core-side dispatch
//               logic: LAA opcode encoding, funct codes, sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package laa_pkg;

    // Operation presented to the LAA on the request interface
    typedef enum logic [1:0] {
        LAA_NONE     = 2'd0,
        LAA_READ     = 2'd1,
        LAA_WRITE    = 2'd2,
        LAA_MULTIPLY = 2'd3
    } LAA_opcode;

    // funct field (ins[11:7]) values of the custom-0 LAA instructions
    localparam logic [4:0] LAA_F_WRITE = 5'b00010;
    localparam logic [4:0] LAA_F_READ  = 5'b00001;
    localparam logic [4:0] LAA_F_EXEC  = 5'b00011;

    // Dispatch sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WB        = 2'd2,
        ST_EXEC_WAIT = 2'd3
    } laa_dispatch_state_t;

endpackage
`default_nettype wire

// File: rtl/laa_ins_decode.sv
`default_nettype none
// ============================================================================
// Module      : laa_ins_decode
// Description : Combinational decode of an LAA instruction word: opcode
//               match, field extraction, legality check and op mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module laa_ins_decode
    import laa_pkg::*;
#(
    parameter int         LAA_REGS = 32,
    parameter logic [6:0] LAA_OPC  = 7'b0001011
) (
    input  logic [31:0] ins,
    output logic        is_laa,
    output logic        legal,
    output LAA_opcode   op,
    output logic [4:0]  laa_idx,
    output logic [4:0]  core_idx
);

    // LAA_REGS is at most 32, so six bits hold it without loss
    localparam logic [5:0] c_regs = 6'(LAA_REGS);

    logic w_funct_ok;
    logic w_unused_bits;

    assign w_unused_bits = ^ins[21:12];

    // Map funct to an LAA op and pick the register fields for that op
    always_comb begin
        is_laa     = (ins[6:0] == LAA_OPC);
        op         = LAA_NONE;
        laa_idx    = 5'd0;
        core_idx   = 5'd0;
        w_funct_ok = 1'b1;
        case (ins[11:7])
            LAA_F_WRITE: begin
                op       = LAA_WRITE;
                laa_idx  = ins[26:22];
                core_idx = ins[31:27];
            end
            LAA_F_READ: begin
                op       = LAA_READ;
                laa_idx  = ins[31:27];
                core_idx = ins[26:22];
            end
            LAA_F_EXEC: begin
                op = LAA_MULTIPLY;
            end
            default: begin
                w_funct_ok = 1'b0;
            end
        endcase
        // EXECUTE carries no register index, laa_idx stays 0 and always passes
        legal = w_funct_ok && ({1'b0, laa_idx} < c_regs);
    end

endmodule
`default_nettype wire

// File: rtl/laa_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : laa_dispatch_ctrl
// Description : Core-side sequencer for the Linear Algebra Accelerator.
//               Accepts decoded LAA instructions, runs the req/ack handshake,
//               writes READ results back to the core, waits for EXECUTE with
//               a timeout, and stalls the core through busy.
// Revision    : 1.0 - initial release
// ============================================================================
module laa_dispatch_ctrl
    import laa_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         LAA_REGS = 32,
    parameter logic [6:0] LAA_OPC  = 7'b0001011,
    parameter int         EXEC_TMO = 1024
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            ins_valid,
    input  logic [31:0]     ins,
    output logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_regwrite,
    output logic            busy,
    output logic            illegal,
    output logic            err_tmo,
    output logic            laa_req,
    output logic [1:0]      laa_op,
    output logic [4:0]      laa_addr,
    output logic [XLEN-1:0] laa_wdata,
    input  logic            laa_ack,
    input  logic [XLEN-1:0] laa_rdata,
    input  logic            laa_done
);

    localparam int                 c_cnt_w    = $clog2(EXEC_TMO);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(EXEC_TMO - 1);

    laa_dispatch_state_t r_state, w_state_nxt;
    LAA_opcode           r_op, w_op_nxt;
    logic [4:0]          r_laa_addr, w_laa_addr_nxt;
    logic [4:0]          r_rd, w_rd_nxt;
    logic [XLEN-1:0]     r_wdata, w_wdata_nxt;
    logic [XLEN-1:0]     r_rdata, w_rdata_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic                r_err_tmo, w_err_tmo_nxt;
    logic                r_illegal, w_illegal_nxt;

    logic                w_is_laa;
    logic                w_legal;
    LAA_opcode           w_dec_op;
    logic [4:0]          w_laa_idx;
    logic [4:0]          w_core_idx;
    logic                w_accept;

    laa_ins_decode #(
        .LAA_REGS (LAA_REGS),
        .LAA_OPC  (LAA_OPC)
    ) u_decode (
        .ins      (ins),
        .is_laa   (w_is_laa),
        .legal    (w_legal),
        .op       (w_dec_op),
        .laa_idx  (w_laa_idx),
        .core_idx (w_core_idx)
    );

    assign w_accept = (r_state == ST_IDLE) && ins_valid && w_is_laa && w_legal;

    // State and field registers; reset returns to IDLE with all outputs low
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_op       <= LAA_NONE;
            r_laa_addr <= '0;
            r_rd       <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_err_tmo  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_laa_addr <= w_laa_addr_nxt;
            r_rd       <= w_rd_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rdata    <= w_rdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_tmo  <= w_err_tmo_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    // Next-state logic: accept, handshake, writeback and EXECUTE wait/timeout
    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_laa_addr_nxt = r_laa_addr;
        w_rd_nxt       = r_rd;
        w_wdata_nxt    = r_wdata;
        w_rdata_nxt    = r_rdata;
        w_cnt_nxt      = r_cnt;
        w_err_tmo_nxt  = r_err_tmo;
        w_illegal_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ins_valid && w_is_laa) begin
                    if (w_legal) begin
                        w_state_nxt    = ST_REQ;
                        w_op_nxt       = w_dec_op;
                        w_laa_addr_nxt = w_laa_idx;
                        if (w_dec_op == LAA_WRITE) begin
                            w_wdata_nxt = rs1_data;
                        end
                        if (w_dec_op == LAA_READ) begin
                            w_rd_nxt = w_core_idx;
                        end
                        // A new EXECUTE clears the previous timeout report
                        if (w_dec_op == LAA_MULTIPLY) begin
                            w_err_tmo_nxt = 1'b0;
                        end
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (laa_ack) begin
                    case (r_op)
                        LAA_WRITE: w_state_nxt = ST_IDLE;
                        LAA_READ: begin
                            w_rdata_nxt = laa_rdata;
                            w_state_nxt = ST_WB;
                        end
                        default: begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_EXEC_WAIT;
                        end
                    endcase
                end
            end
            ST_WB: begin
                w_state_nxt = ST_IDLE;
            end
            ST_EXEC_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // done takes priority over a coincident timeout
                if (laa_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_tmo_last) begin
                    w_err_tmo_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output drive; busy covers the accept cycle combinationally
    always_comb begin
        rs1_addr    = ins[31:27];
        busy        = !Rst && ((r_state != ST_IDLE) || w_accept);
        laa_req     = (r_state == ST_REQ);
        laa_op      = r_op;
        laa_addr    = r_laa_addr;
        laa_wdata   = r_wdata;
        rd_addr     = r_rd;
        wb_data     = r_rdata;
        wb_regwrite = (r_state == ST_WB) && (r_rd != 5'd0);
        illegal     = r_illegal;
        err_tmo     = r_err_tmo;
    end

endmodule
`default_nettype wire
